cdb_arbiter: RTL
================

# cdb_arbiter

Common Data Bus arbiter for the out-of-order core. Each cycle it picks one of NUM_REQ functional-unit result requests (ALU, MUL, DIV, LSU, …) using a rotating round-robin priority and returns a one-hot grant to the winner. It registers the winner's result onto the broadcast CDB that feeds the reservation stations, ROB and physical register file. It is the grant side of the request/grant handshake used by the execution units, which hold `valid` until granted.

## Interface
Parameters:
- NUM_REQ, 4, number of requesting functional units (2–8); index 0 has highest priority after reset.
- CNT_W, 16, width of the saturating contention counter.

Ports:
- clk  input  1  core clock.
- rst  input  1  asynchronous, active-high reset.
- flush  input  1  pipeline flush from the ROB (mispredict/exception).
- fu_cdb  input  cdb_t [NUM_REQ]  per-FU request; `.valid` = request, `.data`/`.preg`/`.rob_id` = payload.
- cdb_grant  output  NUM_REQ  one-hot (or zero) grant, combinational from the current `fu_cdb[*].valid`.
- cdb_out  output  cdb_t  registered broadcast `{valid, data[31:0], preg[5:0], rob_id[4:0]}`.
- contention_cnt  output  CNT_W  saturating count of cycles in which at least one valid request was not granted.

## Operation
- Priority pointer `ptr` (`$clog2(NUM_REQ)` bits) names the highest-priority requester.
  - Search order: ptr, ptr+1, …, wrapping modulo NUM_REQ.
  - The first index with `.valid=1` wins.
- Grant:
  - `cdb_grant[w]=1` for winner w; all other bits 0.
  - No valid requests gives `cdb_grant=0`.
  - `flush=1` forces `cdb_grant=0` regardless of requests.
- Pointer update on a clock edge with a grant and no flush: `ptr <= (w+1) mod NUM_REQ`. Otherwise `ptr` holds.
  - NUM_REQ not a power of 2: wrap explicitly; `ptr` never holds an index ≥ NUM_REQ.
- Output register, one of three cases per edge:
  - Grant issued: `cdb_out <= fu_cdb[w]` with `.valid=1`.
  - No grant: `cdb_out.valid <= 0`; payload fields hold their previous value.
  - flush: `cdb_out.valid <= 0`, which also kills a result granted in the same cycle.
- Requester contract: a requester keeps `.valid` and payload stable until it sees `cdb_grant` high, then drops or replaces them the next cycle. An ungranted request must never be lost. The arbiter stores no request state beyond `ptr`.
- contention_cnt:
  - Increments when `popcount(valid requests) > 1`, or when any valid request sees `cdb_grant=0` due to flush.
  - Saturates at all-ones and never wraps.
- Reset (async, immediate):
  - `ptr=0`
  - `cdb_out` all fields 0
  - `contention_cnt=0`
  - `cdb_grant` follows the combinational rule, with `ptr=0`.

## Timing
- Request to grant: 0 cycles (combinational, same cycle).
- Grant to broadcast: 1 cycle. `cdb_out.valid` is high on the cycle after the grant edge and for exactly one cycle per grant.
- Throughput: one result per cycle. Back-to-back grants to different or the same FU are allowed.
- Fairness: a continuously valid requester is granted within NUM_REQ cycles.
- Simultaneous flush and request: no grant, no pointer change, no broadcast next cycle.
- Reset asserted mid-stream: `cdb_out.valid` drops asynchronously with no partial broadcast. The first grant after reset release starts searching from index 0.
- No combinational path from `cdb_out` to `cdb_grant`. The only path to `cdb_grant` is `fu_cdb[*].valid`/`flush` → grant.

## Test plan
- Reset then single request: `fu_cdb[2]={1,32'hDEADBEEF,6'd17,5'd9}` held one cycle → `cdb_grant=4'b0100` the same cycle; next cycle `cdb_out={1,DEADBEEF,17,9}`; `ptr=3`.
- All four valid continuously for 8 cycles from reset → grants 0,1,2,3,0,1,2,3; `contention_cnt=8`; `cdb_out.valid` high on 8 consecutive cycles with matching payloads.
- Pointer wrap: `ptr=3`, requests from 1 and 3 → grant 3, then grant 1 next cycle (ptr=0 search), then `ptr=2`.
- Flush with `fu_cdb[0].valid=1` → `cdb_grant=0`, next-cycle `cdb_out.valid=0`, `ptr` unchanged, `contention_cnt` +1. After flush drops, the held request is granted.
- Divider-style hold: FU1 asserts valid for 3 cycles while FU0 is also valid, with `ptr=0` → FU0 granted first, FU1 granted the following cycle. FU1's payload is broadcast exactly once, with no duplicate.
- Assert `rst` asynchronously between clock edges while `cdb_out.valid=1` → `cdb_out` goes to 0 immediately; with CNT_W=2 forced into contention for 5 cycles first, the counter had read 3 (saturated) before reset and reads 0 after.

Source files
------------

// File: rtl/cdb_arbiter.sv
// Common Data Bus arbiter: rotating round-robin selection among the
// functional-unit result requests, a one-cycle registered broadcast of the
// winner, and a saturating count of cycles that saw contention.

package cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [31:0] data;
        logic [5:0]  preg;
        logic [4:0]  rob_id;
    } cdb_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  cdb_t               fu_cdb [NUM_REQ],
    output logic [NUM_REQ-1:0] cdb_grant,
    output cdb_t               cdb_out,
    output logic [CNT_W-1:0]   contention_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0] ptr;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             grant_any;
    cdb_t             win_cdb;
    logic             any_valid;
    logic             multi_req;
    logic             contend;
    int               req_count;

    // Search from ptr upward with explicit wrap so non-power-of-two sizes never index past NUM_REQ
    always_comb begin
        found   = 1'b0;
        win     = '0;
        win_cdb = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (!found && fu_cdb[idx].valid) begin
                found   = 1'b1;
                win     = PTR_W'(idx);
                win_cdb = fu_cdb[idx];
            end
        end
    end

    // Count valid requests to detect more than one competing for the bus
    always_comb begin
        req_count = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (fu_cdb[i].valid) begin
                req_count = req_count + 1;
            end
        end
    end

    assign any_valid = (req_count > 0);
    assign multi_req = (req_count > 1);
    assign grant_any = found && !flush;
    assign contend   = multi_req || (flush && any_valid);

    // One-hot grant to the winner; flush suppresses every grant
    always_comb begin
        cdb_grant = '0;
        if (grant_any) begin
            cdb_grant[win] = 1'b1;
        end
    end

    // Advance the priority pointer past the winner only when a grant really issued
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + PTR_W'(1);
        end
    end

    // Broadcast register: payload holds when idle so only valid toggles
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cdb_out <= '0;
        end else if (grant_any) begin
            cdb_out       <= win_cdb;
            cdb_out.valid <= 1'b1;
        end else begin
            cdb_out.valid <= 1'b0;
        end
    end

    // Saturating contention counter, never wraps back to zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            contention_cnt <= '0;
        end else if (contend && (contention_cnt != {CNT_W{1'b1}})) begin
            contention_cnt <= contention_cnt + CNT_W'(1);
        end
    end

endmodule
